// File: rtl/ps_bc_bus_sched.sv
// rtl/ps_bc_bus_sched.sv - BC bus scheduler: sequenced ownership of the shared bus-connect path
// Requesters: [0]=PC stack, [1]=DM access, [2]=ureg transfer, [3]=immediate load.
// Optional macro PS_BC_RR_EN: round-robin arbitration instead of fixed priority (imm > stack > DM > ureg).
module ps_bc_bus_sched #(
   parameter int               TMO_W   = 4,
   parameter logic [TMO_W-1:0] TMO_MAX = TMO_W'(12)
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] ps_bc_req,
   input  logic       ps_popstck,
   input  logic       ps_dm_wrb,
   input  logic [3:0] ps_ureg_add,
   input  logic       ps_dm_ack,
   output logic [3:0] ps_bc_gnt,
   output logic [1:0] ps_bc_drr_slct,
   output logic [2:0] ps_bc_di_slct,
   output logic       ps_bc_stall,
   output logic       ps_bc_tmout
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_GRANT = 2'd1,
      ST_WAIT  = 2'd2
   } state_t;

   localparam logic [TMO_W-1:0] TMO_LAST = TMO_MAX - TMO_W'(1);
   localparam logic [1:0]       DRR_IDLE = 2'b11;
   localparam logic [2:0]       DI_IDLE  = 3'b011;

   state_t           state_q, state_d;
   logic [3:0]       gnt_q, gnt_d;
   logic [1:0]       drr_q, drr_d;
   logic [2:0]       di_q, di_d;
   logic [TMO_W-1:0] cnt_q, cnt_d;
   logic             tmout_q, tmout_d;
   logic [3:0]       arb_req;
   logic [3:0]       win;
   logic [4:0]       win_sel;
   logic             reload;
`ifdef PS_BC_RR_EN
   logic [1:0]       ptr_q, ptr_d;
`endif

   // Fixed priority: immediate first, then stack, DM, ureg transfer.
   function automatic logic [3:0] arb_fixed(input logic [3:0] r);
      logic [3:0] g;
      g = 4'b0000;
      if (r[3])      g = 4'b1000;
      else if (r[0]) g = 4'b0001;
      else if (r[1]) g = 4'b0010;
      else if (r[2]) g = 4'b0100;
      return g;
   endfunction

`ifdef PS_BC_RR_EN
   // Search starts at the pointer; walking downward lets the pointer slot win last.
   function automatic logic [3:0] arb_rr(input logic [3:0] r, input logic [1:0] p);
      logic [3:0] g;
      logic [1:0] idx;
      g = 4'b0000;
      for (int i = 3; i >= 0; i--) begin
         idx = p + 2'(i);
         if (r[idx]) g = 4'(1) << idx;
      end
      return g;
   endfunction

   function automatic logic [1:0] win_idx(input logic [3:0] g);
      logic [1:0] idx;
      idx = 2'd0;
      for (int i = 0; i < 4; i++) begin
         if (g[i]) idx = 2'(i);
      end
      return idx;
   endfunction
`endif

   // Returns {drr, di} for a one-hot winner; an empty grant yields the idle codes.
   function automatic logic [4:0] sel_codes(input logic [3:0] g, input logic pop,
                                            input logic wrb, input logic [3:0] ua);
      logic [1:0] drr;
      logic [2:0] di;
      drr = DRR_IDLE;
      di  = DI_IDLE;
      if (g[3]) begin
         drr = 2'b11;
         di  = 3'b010;
      end else if (g[0]) begin
         // push and pop share the same stack path through the BC mux
         drr = 2'b01;
         di  = pop ? 3'b001 : 3'b001;
      end else if (g[1] && !wrb) begin
         drr = 2'b11;
         di  = 3'b000;
      end else if (g[1] || g[2]) begin
         di = 3'b001;
         case (ua)
            4'h0:       drr = 2'b10;
            4'h1, 4'h2: drr = 2'b00;
            4'h6, 4'h7: drr = 2'b01;
            default:    drr = 2'b11;
         endcase
      end
      return {drr, di};
   endfunction

   // Arbitration candidate: the current owner is masked so it cannot be re-granted back to back.
   always_comb begin
      arb_req = ps_bc_req & ~gnt_q;
`ifdef PS_BC_RR_EN
      win = arb_rr(arb_req, ptr_q);
`else
      win = arb_fixed(arb_req);
`endif
      win_sel = sel_codes(win, ps_popstck, ps_dm_wrb, ps_ureg_add);
   end

   // Next-state, grant and select sequencing; selects are only loaded when a new grant is taken.
   always_comb begin
      state_d = state_q;
      gnt_d   = gnt_q;
      drr_d   = drr_q;
      di_d    = di_q;
      cnt_d   = cnt_q;
      tmout_d = tmout_q;
      reload  = 1'b0;
`ifdef PS_BC_RR_EN
      ptr_d   = ptr_q;
`endif
      case (state_q)
         ST_IDLE: begin
            reload = (ps_bc_req != 4'b0000);
         end
         ST_GRANT: begin
            if (gnt_q[1] && !ps_dm_ack) begin
               state_d = ST_WAIT;
               cnt_d   = '0;
            end else begin
               reload = 1'b1;
            end
         end
         ST_WAIT: begin
            // GRANT cycle plus TMO_MAX wait cycles is the longest a DM owner may hold the bus
            if (ps_dm_ack) begin
               reload = 1'b1;
            end else if (cnt_q == TMO_LAST) begin
               tmout_d = 1'b1;
               state_d = ST_IDLE;
               gnt_d   = 4'b0000;
               drr_d   = DRR_IDLE;
               di_d    = DI_IDLE;
            end else begin
               cnt_d = cnt_q + TMO_W'(1);
            end
         end
         default: begin
            state_d = ST_IDLE;
            gnt_d   = 4'b0000;
            drr_d   = DRR_IDLE;
            di_d    = DI_IDLE;
         end
      endcase
      if (reload) begin
         gnt_d           = win;
         {drr_d, di_d}   = win_sel;
         state_d         = (win != 4'b0000) ? ST_GRANT : ST_IDLE;
`ifdef PS_BC_RR_EN
         if (win != 4'b0000) ptr_d = win_idx(win) + 2'd1;
`endif
      end
   end

   // State, grant, select, timeout counter and sticky error registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         gnt_q   <= 4'b0000;
         drr_q   <= DRR_IDLE;
         di_q    <= DI_IDLE;
         cnt_q   <= '0;
         tmout_q <= 1'b0;
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         drr_q   <= drr_d;
         di_q    <= di_d;
         cnt_q   <= cnt_d;
         tmout_q <= tmout_d;
      end
   end

`ifdef PS_BC_RR_EN
   // Round-robin pointer: slot searched first at the next arbitration.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) ptr_q <= 2'd0;
      else     ptr_q <= ptr_d;
   end
`endif

   assign ps_bc_gnt      = gnt_q;
   assign ps_bc_drr_slct = drr_q;
   assign ps_bc_di_slct  = di_q;
   assign ps_bc_tmout    = tmout_q;
   assign ps_bc_stall    = |(ps_bc_req & ~gnt_d);

endmodule

// File: tb/tb_ps_bc_bus_sched.sv
// tb/tb_ps_bc_bus_sched.sv - directed checks plus randomized scoreboard for ps_bc_bus_sched
module tb_ps_bc_bus_sched;
   localparam int TMO_MAX = 12;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] ps_bc_req;
   logic       ps_popstck;
   logic       ps_dm_wrb;
   logic [3:0] ps_ureg_add;
   logic       ps_dm_ack;
   logic [3:0] ps_bc_gnt;
   logic [1:0] ps_bc_drr_slct;
   logic [2:0] ps_bc_di_slct;
   logic       ps_bc_stall;
   logic       ps_bc_tmout;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic [3:0] g;
      logic [1:0] drr;
      logic [2:0] di;
      int         len;
      bit         b2b;
      bit         tmo;
   } exp_t;

   exp_t exp_q[$];

   logic       sb_en = 1'b0;
   int         ack_k = 1;
   int         dm_cnt = 0;
   logic [3:0] cur_g = 4'b0000;
   logic [1:0] cur_drr = 2'b11;
   logic [2:0] cur_di = 3'b011;
   int         cur_len = 0;
   int         cur_gap = 0;
   int         idle_cnt = 0;

   always #5 clk = ~clk;

   ps_bc_bus_sched dut (
      .clk            (clk),
      .rst            (rst),
      .ps_bc_req      (ps_bc_req),
      .ps_popstck     (ps_popstck),
      .ps_dm_wrb      (ps_dm_wrb),
      .ps_ureg_add    (ps_ureg_add),
      .ps_dm_ack      (ps_dm_ack),
      .ps_bc_gnt      (ps_bc_gnt),
      .ps_bc_drr_slct (ps_bc_drr_slct),
      .ps_bc_di_slct  (ps_bc_di_slct),
      .ps_bc_stall    (ps_bc_stall),
      .ps_bc_tmout    (ps_bc_tmout)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      ps_bc_req = 4'b0000;
      ps_dm_ack = 1'b0;
      ps_popstck = 1'b0;
      ps_dm_wrb = 1'b0;
      ps_ureg_add = 4'h0;
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   // Expected {drr, di} for requester index 'who' from the select table.
   function automatic logic [4:0] exp_sel(input int who, input logic wrb, input logic [3:0] ua);
      if (who == 3) return {2'b11, 3'b010};
      if (who == 0) return {2'b01, 3'b001};
      if (who == 1 && !wrb) return {2'b11, 3'b000};
      if (ua == 4'h0) return {2'b10, 3'b001};
      if (ua == 4'h1 || ua == 4'h2) return {2'b00, 3'b001};
      if (ua == 4'h6 || ua == 4'h7) return {2'b01, 3'b001};
      return {2'b11, 3'b001};
   endfunction

   task automatic end_segment();
      exp_t e;
      if (exp_q.size() == 0) begin
         check("sb_unexpected_grant", 32'(cur_g), 32'd0);
         return;
      end
      e = exp_q.pop_front();
      check("sb_gnt", 32'(cur_g), 32'(e.g));
      check("sb_drr", 32'(cur_drr), 32'(e.drr));
      check("sb_di", 32'(cur_di), 32'(e.di));
      check("sb_len", cur_len, e.len);
      if (e.b2b) check("sb_b2b_gap", cur_gap, 0);
      check("sb_tmout", 32'(ps_bc_tmout), 32'(e.tmo));
   endtask

   // Monitor plus requester/DM responders: sample, compare finished grant runs, then react.
   always @(negedge clk) begin
      if (sb_en) begin
         if (ps_bc_gnt != 4'b0000) begin
            if (ps_bc_gnt != cur_g) begin
               if (cur_g != 4'b0000) end_segment();
               cur_g   = ps_bc_gnt;
               cur_drr = ps_bc_drr_slct;
               cur_di  = ps_bc_di_slct;
               cur_len = 1;
               cur_gap = idle_cnt;
               idle_cnt = 0;
            end else begin
               cur_len++;
               check("sb_sel_held", 32'({ps_bc_drr_slct, ps_bc_di_slct}), 32'({cur_drr, cur_di}));
            end
         end else begin
            if (cur_g != 4'b0000) begin
               end_segment();
               cur_g = 4'b0000;
               idle_cnt = 0;
            end
            idle_cnt++;
            check("sb_idle_sel", 32'({ps_bc_drr_slct, ps_bc_di_slct}), 32'(5'b11011));
         end
         ps_bc_req = ps_bc_req & ~ps_bc_gnt;
         if (ps_bc_gnt[1]) begin
            dm_cnt++;
            ps_dm_ack = (dm_cnt == ack_k);
            if (!ps_bc_req[2]) begin
               ps_ureg_add = 4'($urandom);
               ps_dm_wrb = 1'($urandom);
            end
            if (!ps_bc_req[0]) ps_popstck = 1'($urandom);
         end else begin
            dm_cnt = 0;
            ps_dm_ack = 1'b0;
         end
      end
   end

   initial begin
      int held;
      logic [3:0] first_g, second_g;
      logic [4:0] first_sel, second_sel;
      int m_ptr;
      bit m_tmout;
`ifndef PS_BC_RR_EN
      int fixed_ord[4];
      fixed_ord = '{3, 0, 1, 2};
`endif

      // reset values and single stack push
      do_reset();
      check("rst_gnt", 32'(ps_bc_gnt), 32'd0);
      check("rst_drr", 32'(ps_bc_drr_slct), 32'(2'b11));
      check("rst_di", 32'(ps_bc_di_slct), 32'(3'b011));
      check("rst_stall", 32'(ps_bc_stall), 32'd0);
      check("rst_tmout", 32'(ps_bc_tmout), 32'd0);
      ps_bc_req = 4'b0001;
      ps_popstck = 1'b0;
      ps_ureg_add = 4'h6;
      #1;
      check("t1_stall", 32'(ps_bc_stall), 32'd0);
      tick();
      check("t1_gnt", 32'(ps_bc_gnt), 32'(4'b0001));
      check("t1_drr", 32'(ps_bc_drr_slct), 32'(2'b01));
      check("t1_di", 32'(ps_bc_di_slct), 32'(3'b001));
      ps_bc_req = 4'b0000;
      tick();
      check("t1_rel_gnt", 32'(ps_bc_gnt), 32'd0);
      check("t1_rel_drr", 32'(ps_bc_drr_slct), 32'(2'b11));
      check("t1_rel_di", 32'(ps_bc_di_slct), 32'(3'b011));

      // immediate and DM requested together: back-to-back grants
`ifdef PS_BC_RR_EN
      first_g = 4'b0010;  first_sel = 5'b11000;
      second_g = 4'b1000; second_sel = 5'b11010;
`else
      first_g = 4'b1000;  first_sel = 5'b11010;
      second_g = 4'b0010; second_sel = 5'b11000;
`endif
      do_reset();
      ps_dm_wrb = 1'b0;
      ps_dm_ack = 1'b1;
      ps_bc_req = 4'b1010;
      #1;
      check("t2_stall", 32'(ps_bc_stall), 32'd1);
      tick();
      check("t2_gnt1", 32'(ps_bc_gnt), 32'(first_g));
      check("t2_sel1", 32'({ps_bc_drr_slct, ps_bc_di_slct}), 32'(first_sel));
      ps_bc_req = ps_bc_req & ~first_g;
      tick();
      check("t2_gnt2", 32'(ps_bc_gnt), 32'(second_g));
      check("t2_sel2", 32'({ps_bc_drr_slct, ps_bc_di_slct}), 32'(second_sel));
      ps_bc_req = 4'b0000;
      tick();
      check("t2_rel", 32'(ps_bc_gnt), 32'd0);
      ps_dm_ack = 1'b0;

      // DM read acked in the third wait cycle; selects ignore later qualifier changes
      do_reset();
      ps_bc_req = 4'b0010;
      ps_dm_wrb = 1'b0;
      ps_ureg_add = 4'h5;
      tick();
      check("t3_gnt_c1", 32'(ps_bc_gnt), 32'(4'b0010));
      check("t3_sel_c1", 32'({ps_bc_drr_slct, ps_bc_di_slct}), 32'(5'b11000));
      ps_bc_req = 4'b0000;
      ps_dm_wrb = 1'b1;
      ps_ureg_add = 4'h1;
      tick();
      check("t3_gnt_c2", 32'(ps_bc_gnt), 32'(4'b0010));
      ps_bc_req = 4'b0100;
      #1;
      check("t3_wait_stall", 32'(ps_bc_stall), 32'd1);
      tick();
      check("t3_gnt_c3", 32'(ps_bc_gnt), 32'(4'b0010));
      check("t3_di_held", 32'(ps_bc_di_slct), 32'(3'b000));
      tick();
      check("t3_gnt_c4", 32'(ps_bc_gnt), 32'(4'b0010));
      ps_dm_ack = 1'b1;
      tick();
      check("t3_next_gnt", 32'(ps_bc_gnt), 32'(4'b0100));
      check("t3_next_sel", 32'({ps_bc_drr_slct, ps_bc_di_slct}), 32'(5'b00001));
      check("t3_tmout", 32'(ps_bc_tmout), 32'd0);
      ps_dm_ack = 1'b0;
      ps_bc_req = 4'b0000;
      tick();
      check("t3_rel", 32'(ps_bc_gnt), 32'd0);

      // DM write never acked: timeout and sticky flag
      do_reset();
      ps_bc_req = 4'b0010;
      ps_dm_wrb = 1'b1;
      ps_ureg_add = 4'h0;
      tick();
      check("t4_gnt", 32'(ps_bc_gnt), 32'(4'b0010));
      check("t4_sel", 32'({ps_bc_drr_slct, ps_bc_di_slct}), 32'(5'b10001));
      ps_bc_req = 4'b0000;
      ps_ureg_add = 4'h7;
      held = 1;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (ps_bc_gnt != 4'b0010) break;
         held++;
         check("t4_drr_held", 32'(ps_bc_drr_slct), 32'(2'b10));
      end
      check("t4_held_cycles", held, TMO_MAX + 1);
      check("t4_tmout_set", 32'(ps_bc_tmout), 32'd1);
      check("t4_rel_sel", 32'({ps_bc_gnt, ps_bc_drr_slct, ps_bc_di_slct}), 32'(9'b0000_11_011));
      ps_bc_req = 4'b1000;
      tick();
      check("t4_after_gnt", 32'(ps_bc_gnt), 32'(4'b1000));
      ps_bc_req = 4'b0000;
      tick();
      tick();
      check("t4_tmout_sticky", 32'(ps_bc_tmout), 32'd1);

      // asynchronous reset in the middle of a DM wait (tmout still set from above)
      ps_bc_req = 4'b0010;
      ps_dm_wrb = 1'b0;
      tick();
      ps_bc_req = 4'b0000;
      tick();
      tick();
      check("t5_in_wait", 32'(ps_bc_gnt), 32'(4'b0010));
      #2;
      rst = 1'b1;
      #1;
      check("t5_gnt", 32'(ps_bc_gnt), 32'd0);
      check("t5_sel", 32'({ps_bc_drr_slct, ps_bc_di_slct}), 32'(5'b11011));
      check("t5_tmout", 32'(ps_bc_tmout), 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;

      // stack and ureg contending
      do_reset();
      ps_bc_req = 4'b0101;
      ps_ureg_add = 4'h2;
`ifdef PS_BC_RR_EN
      for (int i = 0; i < 6; i++) begin
         tick();
         check("t6_rr_alt", 32'(ps_bc_gnt), (i % 2 == 0) ? 32'(4'b0001) : 32'(4'b0100));
      end
`else
      tick();
      check("t6_gnt1", 32'(ps_bc_gnt), 32'(4'b0001));
      ps_bc_req = 4'b0100;
      #1;
      check("t6_stall", 32'(ps_bc_stall), 32'd0);
      tick();
      check("t6_gnt2", 32'(ps_bc_gnt), 32'(4'b0100));
      check("t6_sel2", 32'({ps_bc_drr_slct, ps_bc_di_slct}), 32'(5'b00001));
`endif
      ps_bc_req = 4'b0000;
      tick();
      tick();

      // randomized episodes against the scoreboard
      do_reset();
      @(negedge clk);
      #1;
      m_ptr = 0;
      m_tmout = 1'b0;
      cur_g = 4'b0000;
      idle_cnt = 0;
      sb_en = 1'b1;
      for (int ep = 0; ep < 60; ep++) begin
         logic [3:0] mask;
         logic       wrb;
         logic [3:0] ua;
         int         k;
         int         ptr0;
         bit         first;
         bit         prev_tmo;
         bit         tmo_now;
         bit         done;
         exp_t       e;
         mask = 4'($urandom_range(1, 15));
         wrb = 1'($urandom);
         ua = 4'($urandom_range(0, 15));
         k = $urandom_range(1, 16);
         ptr0 = m_ptr;
         first = 1'b1;
         prev_tmo = 1'b0;
         for (int s = 0; s < 4; s++) begin
            int who;
`ifdef PS_BC_RR_EN
            who = (ptr0 + s) % 4;
`else
            who = fixed_ord[s];
`endif
            if (mask[who]) begin
               e.g = 4'(1 << who);
               {e.drr, e.di} = exp_sel(who, wrb, ua);
               if (who == 1) begin
                  e.len = (k <= TMO_MAX + 1) ? k : TMO_MAX + 1;
                  tmo_now = (k > TMO_MAX + 1);
               end else begin
                  e.len = 1;
                  tmo_now = 1'b0;
               end
               m_tmout = m_tmout | tmo_now;
               e.tmo = m_tmout;
               e.b2b = !first && !prev_tmo;
               first = 1'b0;
               prev_tmo = tmo_now;
               m_ptr = (who + 1) % 4;
               exp_q.push_back(e);
            end
         end
         ack_k = k;
         ps_dm_wrb = wrb;
         ps_ureg_add = ua;
         ps_popstck = 1'($urandom);
         ps_bc_req = mask;
         done = 1'b0;
         for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            #2;
            if (ps_bc_req == 4'b0000 && ps_bc_gnt == 4'b0000) begin
               done = 1'b1;
               break;
            end
         end
         check("sb_episode_done", 32'(done), 32'd1);
         repeat ($urandom_range(0, 3)) @(negedge clk);
         @(negedge clk);
         #1;
      end
      repeat (3) @(negedge clk);
      check("sb_drain", exp_q.size(), 0);
      sb_en = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
